ascon_uart_hash_bridge: RTL



---
 rtl/ascon_uart_pkg.sv | 23 ++
 rtl/ascon_word_fifo.sv | 61 ++++++
 rtl/ascon_uart_hash_bridge.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_uart_pkg.sv
// Shared types and constants for the Ascon UART hash bridge.
//   issue_state_t : states of the word-issue FSM
//   tx_state_t    : states of the digest transmit FSM
//   CTRL_LAST_BIT : bit of the in-band control byte carrying the last flag
//   BYTE_W        : width of one UART byte
package ascon_uart_pkg;

    typedef enum logic [1:0] {
        I_IDLE = 2'd0,
        I_GAP  = 2'd1,
        I_LOCK = 2'd2
    } issue_state_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_SEND = 2'd1,
        T_WAIT = 2'd2
    } tx_state_t;

    localparam int CTRL_LAST_BIT = 0;
    localparam int BYTE_W        = 8;

endpackage

// File: rtl/ascon_word_fifo.sv
// Synchronous word FIFO with one write and one read port per cycle.
// The read data is shown combinationally from the head entry (first-word
// fall-through), so the consumer registers it in the same cycle it pops.
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, wr_data  : push request and data (ignored when full without a pop)
//   rd_en, rd_data  : pop request and head entry
//   full, empty     : occupancy flags from the wrap-bit pointer compare
module ascon_word_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_wr_s;
    logic             do_rd_s;

    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    // A push into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_rd_s = rd_en && !empty;
    assign do_wr_s = wr_en && (!full || do_rd_s);
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update on push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset because the pointers qualify them.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/ascon_uart_hash_bridge.sv
// Bridge between UART byte cores and the Ascon hash core.
// RX bytes are assembled into message words (optionally preceded by an
// in-band control byte carrying the last flag), queued in a word FIFO,
// issued to the core under core_ready_i, and the resulting digest is
// streamed back byte by byte paced by tx_done_i.
//   clk, rst                 : clock, synchronous active-high reset
//   rx_dv_i, rx_byte_i       : received byte strobe and data
//   msg_last_pin_i           : last-word pin (LAST_MODE = 0)
//   tx_dv_o, tx_byte_o       : transmit byte strobe and data
//   tx_done_i                : transmitter finished a byte
//   msg_in_o, msg_start_o,
//   msg_last_o, core_ready_i : word issue interface to the core
//   hash_in_i, hash_ready_i  : digest from the core
//   overflow_o               : sticky, a completed word was dropped
//   busy_o                   : FIFO non-empty, message in flight or TX active
module ascon_uart_hash_bridge
    import ascon_uart_pkg::*;
#(
    parameter int WORD_BYTES   = 8,
    parameter int DIGEST_BYTES = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int LAST_MODE    = 0,
    parameter int RX_LSB_FIRST = 1,
    parameter int TX_LSB_FIRST = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_dv_i,
    input  logic [7:0]                rx_byte_i,
    input  logic                      msg_last_pin_i,
    output logic                      tx_dv_o,
    output logic [7:0]                tx_byte_o,
    input  logic                      tx_done_i,
    output logic [8*WORD_BYTES-1:0]   msg_in_o,
    output logic                      msg_start_o,
    output logic                      msg_last_o,
    input  logic                      core_ready_i,
    input  logic [8*DIGEST_BYTES-1:0] hash_in_i,
    input  logic                      hash_ready_i,
    output logic                      overflow_o,
    output logic                      busy_o
);

    localparam int W   = BYTE_W * WORD_BYTES;
    localparam int DW  = BYTE_W * DIGEST_BYTES;
    localparam int OFS = (LAST_MODE == 1) ? 1 : 0;
    localparam int GRP = WORD_BYTES + OFS;
    localparam int CW  = $clog2(GRP + 1);
    localparam int TCW = $clog2(DIGEST_BYTES + 1);

    // RX assembly state
    logic [CW-1:0]  byte_cnt_r;
    logic           ctrl_last_r;
    logic [W-1:0]   word_r;
    logic [W-1:0]   word_next_s;
    logic [CW-1:0]  data_idx_s;
    logic [CW-1:0]  pos_s;
    logic           is_ctrl_s;
    logic           word_done_s;
    logic           last_s;

    // FIFO interface
    logic           push_s;
    logic           pop_s;
    logic [W:0]     fifo_rd_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;

    // FSM state
    issue_state_t   issue_state_r;
    tx_state_t      tx_state_r;
    logic [DW-1:0]  shift_r;
    logic [DW-1:0]  shift_next_s;
    logic [TCW-1:0] tx_cnt_r;
    logic           hash_rdy_r;
    logic           hash_rdy_q_r;
    logic           hash_rise_s;
    logic           tx_last_s;
    logic           tx_finish_s;

    // Byte to send first from a digest word, honouring TX order.
    function automatic logic [BYTE_W-1:0] head_byte(input logic [DW-1:0] v);
        if (TX_LSB_FIRST != 0) begin
            head_byte = v[BYTE_W-1:0];
        end else begin
            head_byte = v[DW-1 -: BYTE_W];
        end
    endfunction

    // Discard the byte just sent, bringing the next one to the head.
    function automatic logic [DW-1:0] drop_head(input logic [DW-1:0] v);
        if (TX_LSB_FIRST != 0) begin
            drop_head = v >> BYTE_W;
        end else begin
            drop_head = v << BYTE_W;
        end
    endfunction

    // Merge the incoming byte into the word and detect word completion.
    always_comb begin
        word_next_s = word_r;
        is_ctrl_s   = 1'b0;
        word_done_s = 1'b0;
        data_idx_s  = byte_cnt_r - CW'(OFS);
        if (RX_LSB_FIRST != 0) begin
            pos_s = data_idx_s;
        end else begin
            pos_s = CW'(WORD_BYTES - 1) - data_idx_s;
        end
        if (rx_dv_i) begin
            if ((LAST_MODE == 1) && (byte_cnt_r == '0)) begin
                is_ctrl_s = 1'b1;
            end else begin
                word_next_s[{pos_s, 3'b000} +: BYTE_W] = rx_byte_i;
            end
            if (byte_cnt_r == CW'(GRP - 1)) begin
                word_done_s = 1'b1;
            end else begin
                word_done_s = 1'b0;
            end
        end else begin
            word_done_s = 1'b0;
        end
    end

    assign last_s       = (LAST_MODE == 1) ? ctrl_last_r : msg_last_pin_i;
    assign pop_s        = (issue_state_r == I_IDLE) && !fifo_empty_s && core_ready_i;
    assign push_s       = word_done_s && (!fifo_full_s || pop_s);
    assign hash_rise_s  = hash_rdy_r && !hash_rdy_q_r;
    assign tx_last_s    = (tx_cnt_r == TCW'(DIGEST_BYTES - 1));
    assign tx_finish_s  = (tx_state_r == T_WAIT) && tx_done_i && tx_last_s;
    assign shift_next_s = drop_head(shift_r);

    // RX byte counter, assembly register, control flag and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_r  <= '0;
            ctrl_last_r <= 1'b0;
            word_r      <= '0;
            overflow_o  <= 1'b0;
        end else begin
            if (rx_dv_i) begin
                word_r <= word_next_s;
                if (is_ctrl_s) begin
                    ctrl_last_r <= rx_byte_i[CTRL_LAST_BIT];
                end
                // The counter wraps even when the word is dropped.
                if (word_done_s) begin
                    byte_cnt_r <= '0;
                end else begin
                    byte_cnt_r <= byte_cnt_r + CW'(1);
                end
            end
            if (word_done_s && !push_s) begin
                overflow_o <= 1'b1;
            end
        end
    end

    ascon_word_fifo #(
        .WIDTH (W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_data ({word_next_s, last_s}),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Issue FSM: pop a word, present it with a start strobe, then gap or lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_state_r <= I_IDLE;
            msg_in_o      <= '0;
            msg_last_o    <= 1'b0;
            msg_start_o   <= 1'b0;
        end else begin
            msg_start_o <= 1'b0;
            case (issue_state_r)
                I_IDLE: begin
                    if (pop_s) begin
                        msg_in_o      <= fifo_rd_s[W:1];
                        msg_last_o    <= fifo_rd_s[0];
                        msg_start_o   <= 1'b1;
                        issue_state_r <= fifo_rd_s[0] ? I_LOCK : I_GAP;
                    end
                end
                I_GAP: begin
                    issue_state_r <= I_IDLE;
                end
                I_LOCK: begin
                    // Held until the whole digest has left the transmitter.
                    if (tx_finish_s) begin
                        issue_state_r <= I_IDLE;
                    end
                end
                default: begin
                    issue_state_r <= I_IDLE;
                end
            endcase
        end
    end

    // TX FSM: capture the digest and stream it one byte per tx_done_i.
    // The strobe is registered on entry to T_SEND so it coincides with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r   <= T_IDLE;
            shift_r      <= '0;
            tx_cnt_r     <= '0;
            tx_dv_o      <= 1'b0;
            tx_byte_o    <= '0;
            hash_rdy_r   <= 1'b0;
            hash_rdy_q_r <= 1'b0;
        end else begin
            hash_rdy_r   <= hash_ready_i;
            hash_rdy_q_r <= hash_rdy_r;
            tx_dv_o      <= 1'b0;
            case (tx_state_r)
                T_IDLE: begin
                    if (hash_rise_s && (issue_state_r == I_LOCK)) begin
                        shift_r    <= hash_in_i;
                        tx_cnt_r   <= '0;
                        tx_byte_o  <= head_byte(hash_in_i);
                        tx_dv_o    <= 1'b1;
                        tx_state_r <= T_SEND;
                    end
                end
                T_SEND: begin
                    tx_state_r <= T_WAIT;
                end
                T_WAIT: begin
                    if (tx_done_i) begin
                        if (tx_last_s) begin
                            tx_cnt_r   <= '0;
                            tx_state_r <= T_IDLE;
                        end else begin
                            shift_r    <= shift_next_s;
                            tx_byte_o  <= head_byte(shift_next_s);
                            tx_cnt_r   <= tx_cnt_r + TCW'(1);
                            tx_dv_o    <= 1'b1;
                            tx_state_r <= T_SEND;
                        end
                    end
                end
                default: begin
                    tx_state_r <= T_IDLE;
                end
            endcase
        end
    end

    // Registered activity flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_o <= 1'b0;
        end else begin
            busy_o <= !fifo_empty_s || (issue_state_r != I_IDLE) || (tx_state_r != T_IDLE);
        end
    end

endmodule
